branch_ctrl: RTL and testbench

//  Branch sequencing controller around the execute-stage branch comparator.

---
 rtl/branch_ctrl.sv | 138 +++++++++++++
 tb/tb_branch_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch sequencing controller: BHT-based fetch prediction, execute-stage
// resolution, mispredict flush/redirect sequencing and branch statistics.
module branch_ctrl #(
  parameter int IDX_BITS     = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_is_branch,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int N = 1 << IDX_BITS;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  localparam logic [3:0] FC_INIT = 4'(FLUSH_CYCLES - 1);

  logic [1:0]          bht_q [N];
  logic [1:0]          bht_d [N];
  logic                state_q, state_d;
  logic [3:0]          fcnt_q, fcnt_d;
  logic                flush_q, flush_d;
  logic                rv_q, rv_d;
  logic [31:0]         rpc_q, rpc_d;
  logic [CNT_W-1:0]    bcnt_q, bcnt_d;
  logic [CNT_W-1:0]    mcnt_q, mcnt_d;

  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] x_idx;
  logic                resolve;
  logic                mispred;
  logic                unused_pc_bits;

  assign f_idx = fetch_pc[IDX_BITS+1:2];
  assign x_idx = ex_pc[IDX_BITS+1:2];
  assign unused_pc_bits =
    ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0]};

  // Reads the registered table only: same-cycle updates show up next cycle
  assign pred_taken = fetch_is_branch & bht_q[f_idx][1];

  // Execute inputs during FLUSH belong to squashed instructions
  assign resolve = ex_valid & ex_is_branch & (state_q == ST_IDLE);
  assign mispred = resolve & (ex_taken ^ ex_pred_taken);

  always_comb begin
    bht_d  = bht_q;
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    rpc_d  = rpc_q;
    if (resolve) begin
      if (ex_taken) begin
        if (bht_q[x_idx] != 2'b11)
          bht_d[x_idx] = bht_q[x_idx] + 2'd1;
      end else begin
        if (bht_q[x_idx] != 2'b00)
          bht_d[x_idx] = bht_q[x_idx] - 2'd1;
      end
      bcnt_d = bcnt_q + CNT_W'(1);
    end
    if (mispred) begin
      mcnt_d = mcnt_q + CNT_W'(1);
      rpc_d  = ex_taken ? ex_target : ex_pc + 32'd4;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    flush_d = 1'b0;
    rv_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mispred) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_INIT;
          flush_d = 1'b1;
          rv_d    = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q != 4'd0) begin
          fcnt_d  = fcnt_q - 4'd1;
          flush_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) bht_q[i] <= 2'b01;
      state_q <= ST_IDLE;
      fcnt_q  <= 4'd0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= 32'd0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      bht_q   <= bht_d;
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign branch_cnt     = bcnt_q;
  assign mispred_cnt    = mcnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scenario bench for branch_ctrl: expected output tuples are queued per
// cycle as stimulus is driven and popped one per clock.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_is_branch = 1'b0;
  logic        pred_taken;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic        ex_taken = 1'b0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic [97:0] sb [$];
  logic [97:0] e;

  branch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_pc(fetch_pc), .fetch_is_branch(fetch_is_branch),
    .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [97:0] tup(input logic f, input logic rv,
      input logic [31:0] rpc, input logic [31:0] bc, input logic [31:0] mc);
    return {f, rv, rpc, bc, mc};
  endfunction

  function automatic logic [97:0] obs();
    return {flush, redirect_valid, redirect_pc, branch_cnt, mispred_cnt};
  endfunction

  task automatic drive_ex(input logic tk, input logic pr,
      input logic [31:0] pc, input logic [31:0] tg);
    ex_valid = 1'b1; ex_is_branch = 1'b1;
    ex_taken = tk; ex_pred_taken = pr;
    ex_pc = pc; ex_target = tg;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_is_branch = 1'b0;
    ex_taken = 1'b0; ex_pred_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if (obs() !== 98'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h exp 0", obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    fetch_pc = 32'h100; fetch_is_branch = 1'b1;
    #1;
    n_chk++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pred: got %b exp 0", pred_taken);
    end
    sb.push_back(tup(0, 0, 32'h0, 0, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); n_chk++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset_idle: got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_untrained();
    drive_ex(1, 0, 32'h100, 32'h200);
    sb.push_back(tup(1, 1, 32'h200, 1, 1));
    sb.push_back(tup(1, 0, 32'h200, 1, 1));
    sb.push_back(tup(0, 0, 32'h200, 1, 1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) idle_ex();
      e = sb.pop_front(); n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL untrained c%0d: got %h exp %h", i, obs(), e);
      end
    end
    fetch_pc = 32'h100; fetch_is_branch = 1'b1; #1;
    n_chk++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL untrained_pred: got %b exp 1", pred_taken);
    end
  endtask

  task automatic test_training();
    fetch_pc = 32'h140; fetch_is_branch = 1'b1;
    drive_ex(1, 0, 32'h140, 32'h280);
    #1;
    n_chk++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass: got %b exp 0", pred_taken);
    end
    sb.push_back(tup(1, 1, 32'h280, 2, 2));
    sb.push_back(tup(1, 0, 32'h280, 2, 2));
    sb.push_back(tup(0, 0, 32'h280, 2, 2));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) idle_ex();
      e = sb.pop_front(); n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL train_mis c%0d: got %h exp %h", i, obs(), e);
      end
    end
    n_chk++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL train_pred1: got %b exp 1", pred_taken);
    end
    drive_ex(1, 1, 32'h140, 32'h280);
    sb.push_back(tup(0, 0, 32'h280, 3, 2));
    sb.push_back(tup(0, 0, 32'h280, 4, 2));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (i == 1) idle_ex();
      e = sb.pop_front(); n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL train_ok c%0d: got %h exp %h", i, obs(), e);
      end
    end
    // A saturated counter survives one not-taken and still predicts taken
    drive_ex(0, 1, 32'h140, 32'h280);
    sb.push_back(tup(1, 1, 32'h144, 5, 3));
    sb.push_back(tup(1, 0, 32'h144, 5, 3));
    sb.push_back(tup(0, 0, 32'h144, 5, 3));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) idle_ex();
      e = sb.pop_front(); n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL train_nt c%0d: got %h exp %h", i, obs(), e);
      end
    end
    n_chk++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL train_sat: got %b exp 1", pred_taken);
    end
  endtask

  task automatic test_wrap();
    drive_ex(0, 1, 32'hFFFF_FFFC, 32'h1234);
    sb.push_back(tup(1, 1, 32'h0, 6, 4));
    sb.push_back(tup(1, 0, 32'h0, 6, 4));
    sb.push_back(tup(0, 0, 32'h0, 6, 4));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) idle_ex();
      e = sb.pop_front(); n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL wrap c%0d: got %h exp %h", i, obs(), e);
      end
    end
    ex_valid = 1'b1; ex_is_branch = 1'b0;
    ex_taken = 1'b1; ex_pred_taken = 1'b0;
    sb.push_back(tup(0, 0, 32'h0, 6, 4));
    @(posedge clk); #1;
    idle_ex();
    e = sb.pop_front(); n_chk++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL non_branch: got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_squash();
    drive_ex(1, 0, 32'h180, 32'h300);
    sb.push_back(tup(1, 1, 32'h300, 7, 5));
    sb.push_back(tup(1, 0, 32'h300, 7, 5));
    sb.push_back(tup(0, 0, 32'h300, 7, 5));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) ex_target = 32'h400;
      if (i == 2) idle_ex();
      e = sb.pop_front(); n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL squash c%0d: got %h exp %h", i, obs(), e);
      end
    end
    drive_ex(0, 1, 32'h180, 32'h300);
    sb.push_back(tup(1, 1, 32'h184, 8, 6));
    sb.push_back(tup(1, 0, 32'h184, 8, 6));
    sb.push_back(tup(0, 0, 32'h184, 8, 6));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) idle_ex();
      e = sb.pop_front(); n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL squash_nt c%0d: got %h exp %h", i, obs(), e);
      end
    end
    fetch_pc = 32'h180; fetch_is_branch = 1'b1; #1;
    n_chk++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL squash_bht: got %b exp 0", pred_taken);
    end
  endtask

  task automatic test_reset_mid_flush();
    drive_ex(1, 0, 32'h1C0, 32'h500);
    sb.push_back(tup(1, 1, 32'h500, 9, 7));
    @(posedge clk); #1;
    idle_ex();
    e = sb.pop_front(); n_chk++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL mid_pre: got %h exp %h", obs(), e);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs() !== 98'd0) begin
      n_fail++;
      $display("FAIL mid_async: got %h exp 0", obs());
    end
    fetch_pc = 32'h140; fetch_is_branch = 1'b1; #1;
    n_chk++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_bht: got %b exp 0", pred_taken);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(tup(0, 0, 32'h0, 0, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); n_chk++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL mid_after: got %h exp %h", obs(), e);
    end
  endtask

  initial begin
    test_reset();
    test_untrained();
    test_training();
    test_wrap();
    test_squash();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
